// File: rtl/hps_adapter_util_fifo_ctrl_sc.sv
// Show-ahead valid/ready FIFO controller driving one single-clock MLAB.
// The MLAB's registered read data is used directly as the FIFO output register.
module hps_adapter_util_fifo_ctrl_sc #(
  parameter int    WIDTH      = 8,
  parameter int    ADDR_WIDTH = 5,
  parameter string FAMILY     = "Other",
  parameter int    AF_THRESH  = (2 ** ADDR_WIDTH) - 4
) (
  input  logic                  clk,
  input  logic                  sclr,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [ADDR_WIDTH:0]   usedw,
  output logic                  almost_full,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [WIDTH-1:0]      mem_din,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [WIDTH-1:0]      mem_dout
);

  localparam int PW      = ADDR_WIDTH + 1;
  localparam int DEPTH   = 2 ** ADDR_WIDTH;
  localparam int VIS_LAT = (FAMILY == "S10") ? 1 : 0;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          r_out_valid;

  logic          w_clr;
  logic [PW-1:0] w_usedw;
  logic          w_full;
  logic          w_wr_fire;
  logic          w_rd_fire;
  logic [PW-1:0] w_wr_vis;

  assign w_clr     = sclr | flush;
  assign w_usedw   = r_wr_ptr - r_rd_ptr;
  assign w_full    = (w_usedw == PW'(DEPTH));
  assign w_wr_fire = in_valid & in_ready;

  assign in_ready    = ~w_full & ~w_clr;
  assign usedw       = w_usedw;
  assign almost_full = (w_usedw >= PW'(AF_THRESH));

  assign mem_we    = w_wr_fire;
  assign mem_waddr = r_wr_ptr[ADDR_WIDTH-1:0];
  assign mem_din   = in_data;

  // S10 MLABs register din before the array write, so a new word only
  // becomes readable one cycle after its write fire.
  generate
    if (VIS_LAT == 1) begin : g_vis_delayed
      logic [PW-1:0] r_wr_vis;
      always_ff @(posedge clk) begin
        if (w_clr) r_wr_vis <= '0;
        else       r_wr_vis <= r_wr_ptr;
      end
      assign w_wr_vis = r_wr_vis;
    end else begin : g_vis_direct
      assign w_wr_vis = r_wr_ptr;
    end
  endgenerate

  assign w_rd_fire = (w_wr_vis != r_rd_ptr) & (~r_out_valid | out_ready) & ~w_clr;

  assign mem_re    = w_rd_fire;
  assign mem_raddr = r_rd_ptr[ADDR_WIDTH-1:0];
  assign out_valid = r_out_valid;
  assign out_data  = mem_dout;

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_wr_fire) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_fire) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_out_valid <= w_rd_fire | (r_out_valid & ~out_ready);
    end
  end

endmodule

// File: tb/tb_hps_adapter_util_fifo_ctrl_sc.sv
// Bench for the FIFO controller: an "Other" and an "S10" instance share stimulus,
// each attached to its own behavioural MLAB, with a per-instance ordering scoreboard.
module tb_hps_adapter_util_fifo_ctrl_sc;

  logic       clk = 1'b0;
  logic       sclr = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;

  logic       a_in_ready, a_out_valid, a_almost_full, a_mem_we, a_mem_re;
  logic [7:0] a_out_data, a_mem_din, a_mem_dout;
  logic [5:0] a_usedw;
  logic [4:0] a_mem_waddr, a_mem_raddr;

  logic       b_in_ready, b_out_valid, b_almost_full, b_mem_we, b_mem_re;
  logic [7:0] b_out_data, b_mem_din, b_mem_dout;
  logic [5:0] b_usedw;
  logic [4:0] b_mem_waddr, b_mem_raddr;

  int errors = 0;
  int checks = 0;
  int n_acc_a = 0;
  bit mon_en = 1'b0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  always #5 clk = ~clk;

  hps_adapter_util_fifo_ctrl_sc #(.WIDTH(8), .ADDR_WIDTH(5), .FAMILY("Other"), .AF_THRESH(28)) u_dut_a (
    .clk(clk), .sclr(sclr), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .usedw(a_usedw), .almost_full(a_almost_full),
    .mem_we(a_mem_we), .mem_waddr(a_mem_waddr), .mem_din(a_mem_din),
    .mem_re(a_mem_re), .mem_raddr(a_mem_raddr), .mem_dout(a_mem_dout)
  );

  hps_adapter_util_fifo_ctrl_sc #(.WIDTH(8), .ADDR_WIDTH(5), .FAMILY("S10"), .AF_THRESH(28)) u_dut_b (
    .clk(clk), .sclr(sclr), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .usedw(b_usedw), .almost_full(b_almost_full),
    .mem_we(b_mem_we), .mem_waddr(b_mem_waddr), .mem_din(b_mem_din),
    .mem_re(b_mem_re), .mem_raddr(b_mem_raddr), .mem_dout(b_mem_dout)
  );

  // MLAB models: "Other" writes directly; S10 registers the write port first.
  logic [7:0] mem_a [32];
  logic [7:0] mem_b [32];
  logic       b_we_q = 1'b0;
  logic [4:0] b_wa_q = '0;
  logic [7:0] b_din_q = '0;

  always @(posedge clk) begin
    if (a_mem_we) mem_a[a_mem_waddr] <= a_mem_din;
    if (a_mem_re) a_mem_dout <= mem_a[a_mem_raddr];
    b_we_q  <= b_mem_we;
    b_wa_q  <= b_mem_waddr;
    b_din_q <= b_mem_din;
    if (b_we_q) mem_b[b_wa_q] <= b_din_q;
    if (b_mem_re) b_mem_dout <= mem_b[b_mem_raddr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: push accepted words, pop and compare on each output handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      if (a_out_valid && out_ready) begin
        chk("sb_a_nonempty", 32'(q_a.size() != 0), 1);
        if (q_a.size() != 0) chk("sb_a_data", a_out_data, q_a.pop_front());
      end
      if (b_out_valid && out_ready) begin
        chk("sb_b_nonempty", 32'(q_b.size() != 0), 1);
        if (q_b.size() != 0) chk("sb_b_data", b_out_data, q_b.pop_front());
      end
      if (sclr || flush) begin
        q_a.delete();
        q_b.delete();
      end else begin
        if (in_valid && a_in_ready) begin
          q_a.push_back(in_data);
          n_acc_a++;
        end
        if (in_valid && b_in_ready) q_b.push_back(in_data);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    sclr = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    repeat (n) next_cycle();
    sclr = 1'b0;
  endtask

  typedef struct {
    logic       sclr;
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       e_ir;
    logic       e_we;
    logic       e_re;
    logic       e_ov;
    logic [5:0] e_used;
    logic       e_dchk;
    logic [7:0] e_d;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int acc0;
    int cyc;
    bit seen;

    //           sclr iv  d      ordy ir we re ov used dchk d
    vecs[0]  = '{1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'd1, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 1'b1, 8'hA5};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 8'h00};
    vecs[6]  = '{1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd1, 1'b0, 8'h00};
    vecs[7]  = '{1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'd1, 1'b1, 8'h01};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd2, 1'b1, 8'h01};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'd2, 1'b1, 8'h01};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'd1, 1'b1, 8'h02};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 1'b1, 8'h03};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 8'h03};

    repeat (3) next_cycle();
    mon_en = 1'b1;

    // Table: reset values, single-word latency, back-to-back pops, empty hold.
    for (int i = 0; i < 13; i++) begin
      sclr = vecs[i].sclr; in_valid = vecs[i].iv; in_data = vecs[i].d; out_ready = vecs[i].ordy;
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", i), a_in_ready, vecs[i].e_ir);
      chk($sformatf("v%0d_mem_we", i), a_mem_we, vecs[i].e_we);
      chk($sformatf("v%0d_mem_re", i), a_mem_re, vecs[i].e_re);
      chk($sformatf("v%0d_out_valid", i), a_out_valid, vecs[i].e_ov);
      chk($sformatf("v%0d_usedw", i), a_usedw, vecs[i].e_used);
      if (vecs[i].e_dchk) chk($sformatf("v%0d_out_data", i), a_out_data, vecs[i].e_d);
      if (i == 0) begin
        chk("rst_waddr", a_mem_waddr, 0);
        chk("rst_raddr", a_mem_raddr, 0);
        chk("rst_af", a_almost_full, 0);
      end
      next_cycle();
    end

    // S10 single word: one extra cycle of write visibility.
    do_reset(2);
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    @(negedge clk);
    chk("s10_we_n", b_mem_we, 1);
    next_cycle(); in_valid = 1'b0;
    @(negedge clk);
    chk("s10_re_n1", b_mem_re, 0);
    chk("oth_re_n1", a_mem_re, 1);
    next_cycle();
    @(negedge clk);
    chk("s10_re_n2", b_mem_re, 1);
    chk("s10_ov_n2", b_out_valid, 0);
    chk("oth_ov_n2", a_out_valid, 1);
    next_cycle();
    @(negedge clk);
    chk("s10_ov_n3", b_out_valid, 1);
    chk("s10_data_n3", b_out_data, 8'hA5);
    next_cycle();

    // Fill with out_ready low: DEPTH words in the MLAB plus one in the output register.
    do_reset(2);
    acc0 = n_acc_a;
    in_valid = 1'b1;
    for (int c = 0; c < 45; c++) begin
      in_data = 8'(n_acc_a);
      @(negedge clk);
      if (a_usedw == 6'd27) chk("fill_af_27", a_almost_full, 0);
      if (a_usedw == 6'd28) chk("fill_af_28", a_almost_full, 1);
      next_cycle();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("fill_count", n_acc_a - acc0, 33);
    chk("fill_usedw", a_usedw, 32);
    chk("fill_in_ready", a_in_ready, 0);
    chk("fill_af", a_almost_full, 1);
    chk("fill_s10_usedw", b_usedw, 32);
    next_cycle();

    // Single pop from full: in_ready returns one cycle later.
    out_ready = 1'b1;
    @(negedge clk);
    chk("pop_re", a_mem_re, 1);
    chk("pop_in_ready_same", a_in_ready, 0);
    next_cycle(); out_ready = 1'b0;
    @(negedge clk);
    chk("pop_in_ready_next", a_in_ready, 1);
    chk("pop_usedw", a_usedw, 31);
    next_cycle();

    // Refill to full, then sustained simultaneous in/out.
    in_valid = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      in_data = 8'(n_acc_a);
      @(negedge clk);
      if (!a_in_ready) seen = 1'b1;
      next_cycle();
    end
    chk("refill_full", seen, 1);
    out_ready = 1'b1;
    for (int t = 0; t < 100; t++) begin
      in_data = 8'(n_acc_a);
      @(negedge clk);
      if (t == 0) begin
        chk("thru_t0_in_ready", a_in_ready, 0);
        chk("thru_t0_re", a_mem_re, 1);
      end else begin
        chk("thru_io", a_in_ready & a_out_valid & a_mem_re, 1);
        // Full drops in_ready for one cycle, so the steady in/out level is DEPTH-1.
        chk("thru_usedw", a_usedw, 31);
      end
      next_cycle();
    end

    // Random traffic through several pointer wraps, then drain.
    acc0 = n_acc_a;
    cyc = 0;
    while ((n_acc_a - acc0) < 200 && cyc < 3000) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data = 8'(n_acc_a);
      @(negedge clk);
      next_cycle();
      cyc++;
    end
    chk("wrap_accept_timeout", 32'(cyc < 3000), 1);
    in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while ((a_out_valid || a_usedw != 0 || b_out_valid || b_usedw != 0) && cyc < 200) begin
      next_cycle();
      cyc++;
    end
    @(negedge clk);
    chk("wrap_drain_timeout", 32'(cyc < 200), 1);
    chk("wrap_sb_a_empty", q_a.size(), 0);
    chk("wrap_sb_b_empty", q_b.size(), 0);
    next_cycle();

    // sclr for three cycles in the middle of traffic.
    in_valid = 1'b1; out_ready = 1'b0;
    repeat (5) begin
      in_data = 8'(n_acc_a);
      next_cycle();
    end
    sclr = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("sclr_in_ready", a_in_ready, 0);
      next_cycle();
    end
    sclr = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("sclr_rel_in_ready", a_in_ready, 1);
    chk("sclr_rel_out_valid", a_out_valid, 0);
    chk("sclr_rel_usedw", a_usedw, 0);
    chk("sclr_rel_mem_re", a_mem_re, 0);
    next_cycle();
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("sclr_no_stale", a_out_valid | b_out_valid, 0);
      next_cycle();
    end

    // Flush with 17 words in the MLAB and one in the output register.
    out_ready = 1'b0; in_valid = 1'b1;
    acc0 = n_acc_a;
    cyc = 0;
    while ((n_acc_a - acc0) < 18 && cyc < 60) begin
      in_data = 8'(n_acc_a);
      @(negedge clk);
      next_cycle();
      cyc++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_pre_usedw", a_usedw, 17);
    chk("flush_pre_out_valid", a_out_valid, 1);
    next_cycle();
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
    @(negedge clk);
    chk("flush_in_ready", a_in_ready, 0);
    chk("flush_mem_we", a_mem_we, 0);
    next_cycle();
    flush = 1'b0; in_data = 8'h3C;
    @(negedge clk);
    chk("flush_out_valid", a_out_valid, 0);
    chk("flush_usedw", a_usedw, 0);
    chk("flush_in_ready_after", a_in_ready, 1);
    next_cycle();
    in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 10) begin
      @(negedge clk);
      if (a_out_valid) begin
        seen = 1'b1;
        chk("flush_first_out", a_out_data, 8'h3C);
      end
      next_cycle();
      cyc++;
    end
    chk("flush_first_out_seen", seen, 1);
    repeat (4) next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
